framebuffer_scanout: RTL and testbench
======================================

# framebuffer_scanout

Pixel-clock-domain scanout stage between the 2-bit Game Boy framebuffer RAM and the HDMI encoder's `rgb` input. It maps each HDMI pixel coordinate (`cx`, `cy`) to a framebuffer address, using an integer-scaled, centred 160×144 window. It issues the RAM read, compensates for the RAM read latency, and converts the returned shade through a 4-entry palette to 24-bit RGB. Outside the window it emits a border colour, and while the LCD is disabled it emits blank.

## Interface
- `SCALE`, 3: integer upscale factor in both axes.
- `SRC_W`, 160: source width in pixels.
- `SRC_H`, 144: source height in pixels.
- `WIN_X0`, 240: first `cx` of the window (active-area start 160 + centring offset 80).
- `WIN_Y0`, 69: first `cy` of the window (active-area start 45 + centring offset 24).
- `RAM_LATENCY`, 2: clocks from `fb_read_en`/`fb_read_addr` registered to valid `fb_read_data`.
- `PAL0`..`PAL3`, 24'hE0F8D0 / 24'h88C070 / 24'h346856 / 24'h081820: RGB for shades 0..3.
- `BORDER`, 24'h000000: colour outside the window.

Ports:
- `clk`, in, 1: pixel clock.
- `reset_n`, in, 1: reset, active-low and asynchronous.
- `cx`, in, 10: HDMI x coordinate. Increments by 1 per clock and wraps at frame width.
- `cy`, in, 10: HDMI y coordinate. Increments when `cx` wraps.
- `lcd_enable`, in, 1: PPU LCD enable. Asynchronous source (Game Boy clock domain).
- `fb_read_addr`, out, 16: framebuffer address, {src_y[7:0], src_x[7:0]}.
- `fb_read_en`, out, 1: RAM read enable.
- `fb_read_data`, in, 2: shade returned by the RAM.
- `rgb`, out, 24: pixel to the HDMI encoder.

## Operation
- Window test:
  - `in_x` = (WIN_X0 ≤ cx < WIN_X0 + SRC_W·SCALE).
  - `in_y` = (WIN_Y0 ≤ cy < WIN_Y0 + SRC_H·SCALE).
  - `in_win` = `in_x` && `in_y`.
- Source coordinates:
  - src_x = (cx − WIN_X0)/SCALE and src_y = (cy − WIN_Y0)/SCALE.
  - Both are produced by sub-pixel counters, with no divider.
- X counters:
  - On cx == WIN_X0, sub_x and src_x load 0.
  - Otherwise, while `in_x`, sub_x increments. At SCALE−1, sub_x wraps to 0 and src_x increments.
- Y counters:
  - On cy == WIN_Y0 with cx == WIN_X0, sub_y and src_y load 0.
  - On each cx == WIN_X0 + SRC_W·SCALE while `in_y`, sub_y/src_y advance with the same wrap rule as X.
- Counter validity: if `cx`/`cy` jump non-monotonically, the counters self-correct at the next line or window start. Output in between is undefined but must not lock up.
- Read issue: `fb_read_en` = `in_win` (registered). `fb_read_addr` holds the last issued address when not enabled.
- Alignment pipeline: `in_win` is carried through a shift pipeline of depth RAM_LATENCY alongside the read, so the window flag stays aligned with `fb_read_data`.
- Colour select: `rgb` takes the first matching case below.
  - LCD blank (synchronised `lcd_enable` = 0): `rgb` = PAL0.
  - Aligned flag = 0: `rgb` = BORDER.
  - Otherwise: `rgb` = PAL[`fb_read_data`].
- `lcd_enable` passes through a 2-flop synchroniser. The synchronised value is then delayed to align with the pixel pipeline.

## Timing
- Stage layout for inputs sampled at edge t:
  - t+1: `fb_read_addr`/`fb_read_en` registered.
  - t+1+RAM_LATENCY: `fb_read_data` valid.
  - t+2+RAM_LATENCY: `rgb` registered.
- Fixed latency from `cx`/`cy` to `rgb` is RAM_LATENCY+2 clocks, which is 4 at default. The instantiator advances `cx` by this amount.
- `lcd_enable` edge to `rgb` effect: 2 sync clocks plus pipeline alignment, at most RAM_LATENCY+4 clocks. This is not phase-locked to pixels.
- Reset (`reset_n` low, asynchronous) clears:
  - `fb_read_en` = 0, `fb_read_addr` = 0.
  - All counters and pipeline flags = 0.
  - Synchroniser = 0, so `rgb` = PAL0 (blank).
  - `rgb` = 24'h000000 while in reset.
- Reset release: the first in-window pixels are correct from the next cx == WIN_X0 with cy == WIN_Y0.
- Reset asserted mid-frame: outputs go to reset values immediately. No partial state persists.

## Test plan
- Reset hold, then release with `cx`/`cy` sweeping and `lcd_enable` = 1:
  - `rgb` = 0 during reset.
  - `fb_read_en` = 0 until cx=240, cy=69.
- Window start, with RAM model returning shade 3 at address 0x0000: cx=240, cy=69 → at t+1 `fb_read_addr` = 0x0000 and `fb_read_en` = 1; at t+4 `rgb` = 24'h081820.
- X scaling:
  - cx=242 → addr 0x0000.
  - cx=243 → 0x0001.
  - cx=719 → 0x009F.
  - cx=720 → `fb_read_en` = 0, and `rgb` = BORDER 4 clocks later.
- Y scaling:
  - cy=71 → src_y 0.
  - cy=72 → 0x01xx.
  - cy=500 → 0x8Fxx.
  - cy=501 → border for the whole line.
- Deassert `lcd_enable` asynchronously mid-window: within 6 clocks `rgb` = 24'hE0F8D0 regardless of `fb_read_data`. Reassert and confirm palette output resumes.
- Assert `reset_n` low at cx=400, cy=200, hold 5 clocks, then release: outputs are 0 immediately; correct addresses resume at the next frame's window start.

Source files
------------

// File: rtl/framebuffer_scanout.sv
// ---------------------------------------------------------------------------
// framebuffer_scanout
//
// Pixel-clock scanout stage between the 2-bit Game Boy framebuffer RAM and
// the HDMI encoder. Maps each HDMI pixel coordinate to a framebuffer address
// inside an integer-scaled, centred SRC_W x SRC_H window, issues the RAM read,
// keeps the window flag and LCD-enable aligned with the RAM read latency, and
// converts the returned shade to 24-bit RGB through a 4-entry palette.
//
// Ports:
//   clk          in   1   pixel clock
//   reset_n      in   1   asynchronous active-low reset
//   cx, cy       in  10   HDMI pixel coordinates (cx advances each clock)
//   lcd_enable   in   1   PPU LCD enable, asynchronous to clk
//   fb_read_addr out 16   {src_y[7:0], src_x[7:0]}, held when not reading
//   fb_read_en   out  1   RAM read enable (pixel inside the window)
//   fb_read_data in   2   shade, valid RAM_LATENCY clocks after the read
//   rgb          out 24   pixel to the HDMI encoder
//
// Latency from cx/cy to rgb is RAM_LATENCY + 2 clocks.
// ---------------------------------------------------------------------------
module framebuffer_scanout #(
    parameter int          SCALE       = 3,
    parameter int          SRC_W       = 160,
    parameter int          SRC_H       = 144,
    parameter int          WIN_X0      = 240,
    parameter int          WIN_Y0      = 69,
    parameter int          RAM_LATENCY = 2,
    parameter logic [23:0] PAL0        = 24'hE0F8D0,
    parameter logic [23:0] PAL1        = 24'h88C070,
    parameter logic [23:0] PAL2        = 24'h346856,
    parameter logic [23:0] PAL3        = 24'h081820,
    parameter logic [23:0] BORDER      = 24'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  cx,
    input  logic [9:0]  cy,
    input  logic        lcd_enable,
    output logic [15:0] fb_read_addr,
    output logic        fb_read_en,
    input  logic [1:0]  fb_read_data,
    output logic [23:0] rgb
);

    localparam int               SUB_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
    localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
    localparam logic [10:0]      X_BEG    = 11'(WIN_X0);
    localparam logic [10:0]      X_END    = 11'(WIN_X0 + SRC_W * SCALE);
    localparam logic [10:0]      Y_BEG    = 11'(WIN_Y0);
    localparam logic [10:0]      Y_END    = 11'(WIN_Y0 + SRC_H * SCALE);

    function automatic logic [23:0] f_palette(input logic [1:0] shade);
        case (shade)
            2'd0:    f_palette = PAL0;
            2'd1:    f_palette = PAL1;
            2'd2:    f_palette = PAL2;
            default: f_palette = PAL3;
        endcase
    endfunction

    logic [10:0]      w_cx, w_cy;
    logic             w_x_start, w_y_start, w_line_end;
    logic             w_in_x, w_in_y, w_in_win;
    logic [SUB_W-1:0] w_sub_x, w_sub_y;
    logic [7:0]       w_src_x, w_src_y;

    logic [SUB_W-1:0] r_sub_x, r_sub_y;
    logic [7:0]       r_src_x, r_src_y;
    logic             r_vld_p1;
    logic [15:0]      r_addr_p1;
    logic             r_vld_pipe [RAM_LATENCY];
    logic             r_lcd_sync_p0;
    logic             r_lcd_pipe [RAM_LATENCY];
    logic [23:0]      r_rgb;

    assign w_cx       = {1'b0, cx};
    assign w_cy       = {1'b0, cy};
    assign w_x_start  = (w_cx == X_BEG);
    assign w_y_start  = (w_cy == Y_BEG) && w_x_start;
    assign w_line_end = (w_cx == X_END);
    assign w_in_x     = (w_cx >= X_BEG) && (w_cx < X_END);
    assign w_in_y     = (w_cy >= Y_BEG) && (w_cy < Y_END);
    assign w_in_win   = w_in_x && w_in_y;

    // The counter registers hold the position of the *next* pixel; the window
    // start overrides them so a bad cx/cy history cannot survive a new line.
    assign w_sub_x = w_x_start ? '0 : r_sub_x;
    assign w_src_x = w_x_start ? '0 : r_src_x;
    assign w_sub_y = w_y_start ? '0 : r_sub_y;
    assign w_src_y = w_y_start ? '0 : r_src_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sub_x       <= '0;
            r_src_x       <= '0;
            r_sub_y       <= '0;
            r_src_y       <= '0;
            r_vld_p1      <= 1'b0;
            r_addr_p1     <= '0;
            r_lcd_sync_p0 <= 1'b0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                r_vld_pipe[i] <= 1'b0;
                r_lcd_pipe[i] <= 1'b0;
            end
            r_rgb         <= '0;
        end else begin
            // Stage p0 -> p1: sub-pixel counters and RAM read issue
            if (w_in_x) begin
                if (w_sub_x == SUB_LAST) begin
                    r_sub_x <= '0;
                    r_src_x <= w_src_x + 8'd1;
                end else begin
                    r_sub_x <= w_sub_x + SUB_ONE;
                    r_src_x <= w_src_x;
                end
            end else begin
                r_sub_x <= w_sub_x;
                r_src_x <= w_src_x;
            end

            // Source row advances once per window line, at the right edge.
            if (w_in_y && w_line_end) begin
                if (w_sub_y == SUB_LAST) begin
                    r_sub_y <= '0;
                    r_src_y <= w_src_y + 8'd1;
                end else begin
                    r_sub_y <= w_sub_y + SUB_ONE;
                    r_src_y <= w_src_y;
                end
            end else begin
                r_sub_y <= w_sub_y;
                r_src_y <= w_src_y;
            end

            r_vld_p1 <= w_in_win;
            if (w_in_win) begin
                r_addr_p1 <= {w_src_y, w_src_x};
            end

            // The second synchroniser flop doubles as the first alignment
            // stage, so the LCD flag arrives with the same pixel as the data.
            r_lcd_sync_p0 <= lcd_enable;
            r_lcd_pipe[0] <= r_lcd_sync_p0;
            r_vld_pipe[0] <= r_vld_p1;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_lcd_pipe[i] <= r_lcd_pipe[i-1];
            end

            // Stage p(1+RAM_LATENCY) -> output: colour select
            if (!r_lcd_pipe[RAM_LATENCY-1]) begin
                r_rgb <= PAL0;
            end else if (!r_vld_pipe[RAM_LATENCY-1]) begin
                r_rgb <= BORDER;
            end else begin
                r_rgb <= f_palette(fb_read_data);
            end
        end
    end

    assign fb_read_en   = r_vld_p1;
    assign fb_read_addr = r_addr_p1;
    assign rgb          = r_rgb;

endmodule

// File: tb/tb_framebuffer_scanout.sv
module tb_framebuffer_scanout;

    localparam int X0 = 240;
    localparam int X1 = 240 + 160 * 3;   // 720
    localparam int Y0 = 69;
    localparam int Y1 = 69 + 144 * 3;    // 501
    localparam int SC = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  cx, cy;
    logic        lcd_enable;
    logic [15:0] fb_read_addr;
    logic        fb_read_en;
    logic [1:0]  fb_read_data;
    logic [23:0] rgb;

    always #5 clk = ~clk;

    framebuffer_scanout dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cx           (cx),
        .cy           (cy),
        .lcd_enable   (lcd_enable),
        .fb_read_addr (fb_read_addr),
        .fb_read_en   (fb_read_en),
        .fb_read_data (fb_read_data),
        .rgb          (rgb)
    );

    // Framebuffer RAM model: two-clock read latency.
    logic [1:0] mem [0:65535];
    logic [1:0] ram_d1, ram_d2;
    always @(posedge clk) begin
        ram_d1 <= mem[fb_read_addr];
        ram_d2 <= ram_d1;
    end
    assign fb_read_data = ram_d2;

    typedef struct {
        int          due;
        int          px;
        int          py;
        logic        en;
        logic [15:0] addr;
    } rd_t;

    typedef struct {
        int          due;
        int          px;
        int          py;
        logic [23:0] a;
        logic [23:0] b;
    } rgb_t;

    rd_t         q_rd[$];
    rgb_t        q_rgb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [23:0] pal [4];
    logic [15:0] m_last_addr;
    int          m_amb_left;

    task automatic chk(input string nm, input int px, input int py,
                       input logic [23:0] got, input logic [23:0] ea, input logic [23:0] eb);
        n_checks++;
        if (got !== ea && got !== eb) begin
            n_errors++;
            if (ea == eb)
                $display("FAIL %s cx=%0d cy=%0d got=%h expected=%h", nm, px, py, got, ea);
            else
                $display("FAIL %s cx=%0d cy=%0d got=%h expected=%h or %h", nm, px, py, got, ea, eb);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rgb"},  -1, -1, rgb, 24'h0, 24'h0);
        chk({tag, "_en"},   -1, -1, {23'd0, fb_read_en}, 24'h0, 24'h0);
        chk({tag, "_addr"}, -1, -1, {8'd0, fb_read_addr}, 24'h0, 24'h0);
    endtask

    // Monitor: pops each expectation when its output becomes visible.
    initial begin
        rd_t  ir;
        rgb_t ig;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q_rd.size() > 0 && q_rd[0].due <= cyc) begin
                ir = q_rd.pop_front();
                chk("read_en", ir.px, ir.py, {23'd0, fb_read_en}, {23'd0, ir.en}, {23'd0, ir.en});
                chk("read_addr", ir.px, ir.py, {8'd0, fb_read_addr}, {8'd0, ir.addr}, {8'd0, ir.addr});
            end
            while (q_rgb.size() > 0 && q_rgb[0].due <= cyc) begin
                ig = q_rgb.pop_front();
                chk("rgb", ig.px, ig.py, rgb, ig.a, ig.b);
            end
        end
    end

    // Drive one pixel and record what the DUT must show for it.
    task automatic drive(input int x, input int y, input logic lcd, input logic amb_in);
        logic        iw;
        logic        amb;
        logic [15:0] a;
        logic [23:0] norm;
        rd_t         r;
        rgb_t        g;
        @(negedge clk);
        cx         = 10'(x);
        cy         = 10'(y);
        lcd_enable = lcd;
        amb        = amb_in;
        if (m_amb_left > 0) begin
            amb = 1'b1;
            m_amb_left--;
        end
        iw   = (x >= X0) && (x < X1) && (y >= Y0) && (y < Y1);
        norm = 24'h000000;
        if (iw) begin
            a           = {8'((y - Y0) / SC), 8'((x - X0) / SC)};
            m_last_addr = a;
            norm        = pal[mem[a]];
        end
        r.due  = cyc + 1;
        r.px   = x;
        r.py   = y;
        r.en   = iw;
        r.addr = m_last_addr;
        q_rd.push_back(r);
        g.due = cyc + 4;
        g.px  = x;
        g.py  = y;
        if (amb) begin
            g.a = norm;
            g.b = pal[0];
        end else if (!lcd) begin
            g.a = pal[0];
            g.b = pal[0];
        end else begin
            g.a = norm;
            g.b = norm;
        end
        q_rgb.push_back(g);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        q_rd.delete();
        q_rgb.delete();
        chk_reset("midrst_assert");
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset("midrst_hold");
        reset_n     = 1'b1;
        m_last_addr = '0;
        m_amb_left  = 6;
    endtask

    // Full rows are swept contiguously across the window; other window rows
    // only visit the right edge so the row counter still advances.
    task automatic run_frame(input int lcd_row, input int rst_row);
        int   extra1, extra2;
        logic full, lcd, amb, aborted;
        extra1  = int'($urandom_range(76, 498));
        extra2  = int'($urandom_range(76, 498));
        aborted = 1'b0;
        for (int y = 0; y < 525; y++) begin
            full = (y >= 69 && y <= 75) || (y >= 499 && y <= 501) ||
                   y == lcd_row || y == rst_row || y == extra1 || y == extra2;
            if (full) begin
                for (int x = 236; x <= 724; x++) begin
                    if (y == rst_row && x == 400) begin
                        mid_reset();
                        aborted = 1'b1;
                        break;
                    end
                    lcd = 1'b1;
                    amb = 1'b0;
                    if (y == lcd_row) begin
                        lcd = !(x >= 400 && x < 600);
                        amb = (x >= 397 && x <= 401) || (x >= 597 && x <= 601);
                    end
                    drive(x, y, lcd, amb);
                end
            end else if (y >= Y0 && y < Y1) begin
                for (int x = 720; x <= 723; x++) drive(x, y, 1'b1, 1'b0);
            end else if (y == 0) begin
                for (int x = 0; x < 8; x++) drive(x, y, 1'b1, 1'b0);
            end
            if (aborted) break;
        end
    endtask

    initial begin
        pal[0] = 24'hE0F8D0;
        pal[1] = 24'h88C070;
        pal[2] = 24'h346856;
        pal[3] = 24'h081820;
        for (int i = 0; i < 65536; i++) mem[i] = 2'($urandom);
        mem[0] = 2'd3;

        reset_n     = 1'b0;
        cx          = '0;
        cy          = '0;
        lcd_enable  = 1'b1;
        m_last_addr = '0;
        m_amb_left  = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("init");
        reset_n    = 1'b1;
        m_amb_left = 6;

        run_frame(100, -1);
        run_frame(-1, 200);
        run_frame(-1, -1);
        for (int i = 0; i < 8; i++) drive(0, 0, 1'b1, 1'b0);

        repeat (6) @(posedge clk);
        #2;
        n_checks++;
        if (q_rd.size() != 0 || q_rgb.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending_rd=%0d pending_rgb=%0d expected=0", q_rd.size(), q_rgb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
